// File: rtl/segment_hex_scan_if.sv
// rtl/segment_hex_scan_if.sv - display register bundle feeding the hex scanner
interface segment_hex_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] hex_input;
  logic [NUM_DIGITS-1:0]   dp_input;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_suppress;
  logic [3:0]              brightness;

  modport master (output hex_input, dp_input, digit_en, lz_suppress, brightness);
  modport slave  (input  hex_input, dp_input, digit_en, lz_suppress, brightness);
endinterface

// File: rtl/segment_hex_scan.sv
// rtl/segment_hex_scan.sv - time-multiplexed 7-segment hex driver with PWM and per-frame snapshot
module segment_hex_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 512
) (
  input  logic                  clk,
  input  logic                  resetn,
  segment_hex_scan_if.slave     disp,
  output logic [7:0]            cathode_array,
  output logic [NUM_DIGITS-1:0] anode_array,
  output logic                  frame_tick
);
  localparam int          PW     = $clog2(DIGIT_CYCLES);
  localparam int          IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SLOT16 = DIGIT_CYCLES / 16;

  logic [PW-1:0]           r_pres;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_hex;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_en;
  logic                    r_lz;
  logic [3:0]              r_bright;
  logic [7:0]              r_cathode;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic                    r_frame_tick;

  logic                  w_slot_end;
  logic                  w_last_digit;
  logic                  w_wrap;
  logic [3:0]            w_nibble;
  logic [PW:0]           w_on;
  logic [NUM_DIGITS-1:0] w_sup;
  logic                  w_drive;
  logic [6:0]            w_seg;

  assign w_slot_end   = (r_pres == PW'(DIGIT_CYCLES - 1));
  assign w_last_digit = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_wrap       = w_slot_end && w_last_digit;
  assign w_nibble     = r_hex[4*r_idx +: 4];
  assign w_on         = (PW+1)'((32'(r_bright) + 32'd1) * SLOT16);

  // A digit is blank-able only while it and everything above it is a bare zero.
  always_comb begin
    logic chain;
    w_sup = '0;
    chain = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      chain = chain & (r_hex[4*i +: 4] == 4'h0) & ~r_dp[i];
      if (i > 0) w_sup[i] = chain;
    end
  end

  assign w_drive = r_en[r_idx] && ({1'b0, r_pres} < w_on) && !(r_lz && w_sup[r_idx]);

  always_comb begin
    w_seg = 7'h7F;
    case (w_nibble)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pres       <= '0;
      r_idx        <= '0;
      r_hex        <= disp.hex_input;
      r_dp         <= disp.dp_input;
      r_en         <= disp.digit_en;
      r_lz         <= disp.lz_suppress;
      r_bright     <= disp.brightness;
      r_anode      <= '1;
      r_cathode    <= 8'hFF;
      r_frame_tick <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_pres <= '0;
        r_idx  <= w_last_digit ? '0 : r_idx + IW'(1);
      end else begin
        r_pres <= r_pres + PW'(1);
      end
      // Snapshot only at the frame boundary so a frame never mixes old and new values.
      if (w_wrap) begin
        r_hex    <= disp.hex_input;
        r_dp     <= disp.dp_input;
        r_en     <= disp.digit_en;
        r_lz     <= disp.lz_suppress;
        r_bright <= disp.brightness;
      end
      r_frame_tick <= w_wrap;
      if (w_drive) begin
        r_anode   <= ~(NUM_DIGITS'(1) << r_idx);
        r_cathode <= {~r_dp[r_idx], w_seg};
      end else begin
        r_anode   <= '1;
        r_cathode <= 8'hFF;
      end
    end
  end

  assign cathode_array = r_cathode;
  assign anode_array   = r_anode;
  assign frame_tick    = r_frame_tick;
endmodule

// File: tb/tb_segment_hex_scan.sv
// tb/tb_segment_hex_scan.sv - scoreboard bench for segment_hex_scan (4-digit and 1-digit builds)
module tb_segment_hex_scan;
  logic       clk;
  logic       resetn;
  logic [7:0] cat4, cat1;
  logic [3:0] an4;
  logic       an1;
  logic       tick4, tick1;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] cat;
    logic       tick;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  segment_hex_scan_if #(.NUM_DIGITS(4)) bus4();
  segment_hex_scan_if #(.NUM_DIGITS(1)) bus1();

  segment_hex_scan #(.NUM_DIGITS(4), .DIGIT_CYCLES(16)) dut4 (
    .clk(clk), .resetn(resetn), .disp(bus4.slave),
    .cathode_array(cat4), .anode_array(an4), .frame_tick(tick4)
  );

  segment_hex_scan #(.NUM_DIGITS(1), .DIGIT_CYCLES(16)) dut1 (
    .clk(clk), .resetn(resetn), .disp(bus1.slave),
    .cathode_array(cat1), .anode_array(an1), .frame_tick(tick1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int c, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, expv);
    end
  endtask

  // Expected per-cycle outputs of one 4-digit frame; cats holds digit3..digit0 codes.
  task automatic push_frame(input int s, input logic [31:0] cats, input logic [3:0] drv,
                            input int on, input int ncyc);
    exp_t e;
    int   d;
    int   p;
    for (int k = 0; k < ncyc; k++) begin
      d = k / 16;
      p = k % 16;
      e.cyc = s + k;
      if (drv[d] && p < on) begin
        e.an  = ~(4'b0001 << d);
        e.cat = cats[8*d +: 8];
      end else begin
        e.an  = 4'hF;
        e.cat = 8'hFF;
      end
      e.tick = (k == 63);
      q4.push_back(e);
    end
  endtask

  task automatic push_off4(input int first, input int last);
    exp_t e;
    for (int c = first; c <= last; c++) begin
      e.cyc = c; e.an = 4'hF; e.cat = 8'hFF; e.tick = 1'b0;
      q4.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q4.size() > 0 && q4[0].cyc <= cyc) begin
      e = q4.pop_front();
      chk("late4", cyc, 8'(cyc), 8'(e.cyc));
      chk("anode4", e.cyc, {4'h0, an4}, {4'h0, e.an});
      chk("cathode4", e.cyc, cat4, e.cat);
      chk("tick4", e.cyc, {7'h0, tick4}, {7'h0, e.tick});
    end
    while (q1.size() > 0 && q1[0].cyc <= cyc) begin
      e = q1.pop_front();
      chk("anode1", e.cyc, {7'h0, an1}, {7'h0, e.an[0]});
      chk("cathode1", e.cyc, cat1, e.cat);
      chk("tick1", e.cyc, {7'h0, tick1}, {7'h0, e.tick});
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    resetn = 1'b0;
    bus4.hex_input = 16'h1A2F; bus4.dp_input = 4'h0; bus4.digit_en = 4'hF;
    bus4.lz_suppress = 1'b0;   bus4.brightness = 4'd15;
    bus1.hex_input = 4'h9;     bus1.dp_input = 1'b0; bus1.digit_en = 1'b1;
    bus1.lz_suppress = 1'b0;   bus1.brightness = 4'd15;

    push_off4(1, 4);
    push_frame(5,   32'hF988A48E, 4'hF,    16, 64);
    push_frame(69,  32'hC0C0C0C0, 4'hF,    16, 64);
    push_frame(133, 32'hFFFF92C0, 4'b0011, 16, 64);
    push_frame(197, 32'hFF4092C0, 4'b0111, 16, 64);
    push_frame(261, 32'hF988A48E, 4'hF,    4,  64);
    push_frame(325, 32'hF988A48E, 4'hF,    1,  64);
    push_frame(389, 32'hF988A48E, 4'b0101, 16, 64);
    push_frame(453, 32'hF988A48E, 4'b0101, 16, 40);
    push_off4(493, 495);
    push_frame(496, 32'hC0C0C078, 4'hF,    16, 64);

    for (int k = 1; k <= 52; k++) begin
      e.cyc  = k;
      e.an   = (k <= 4) ? 4'h1 : 4'h0;
      e.cat  = (k <= 4) ? 8'hFF : 8'h90;
      e.tick = (k > 4) && ((k - 4) % 16 == 0);
      q1.push_back(e);
    end

    wait_cyc(4);   resetn = 1'b1;
    wait_cyc(24);  bus4.hex_input = 16'h0000;
    wait_cyc(80);  bus4.hex_input = 16'h0050; bus4.lz_suppress = 1'b1;
    wait_cyc(150); bus4.dp_input = 4'b0100;
    wait_cyc(210); bus4.hex_input = 16'h1A2F; bus4.lz_suppress = 1'b0;
                   bus4.dp_input = 4'h0;      bus4.brightness = 4'd3;
    wait_cyc(270); bus4.brightness = 4'd0;
    wait_cyc(340); bus4.brightness = 4'd15;   bus4.digit_en = 4'b0101;
    wait_cyc(492); resetn = 1'b0;
    wait_cyc(493); bus4.hex_input = 16'h0007; bus4.dp_input = 4'b0001; bus4.digit_en = 4'hF;
    wait_cyc(495); resetn = 1'b1;
    wait_cyc(561);

    chk("pending4", cyc, 8'(q4.size()), 8'd0);
    chk("pending1", cyc, 8'(q1.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
